// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: arbiter FSM state enum, byte width, pointer-width helper.
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_GUARD  = 2'd2,
        ST_WAIT   = 2'd3
    } eArbState;

    // Width of a requester index; never narrower than one bit.
    function automatic int ptr_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first valid requester strictly after rr_ptr_i, with wrap.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   req_valid_i  NUM_REQ  per-requester valid
//   rr_ptr_i     PTR_W    index of the last served requester
//   pick_o       NUM_REQ  one-hot winner, 0 when nothing is valid
//   pick_idx_o   PTR_W    binary index of the winner
//   any_valid_o  1        at least one requester is valid
module rr_picker
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = ptr_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [PTR_W-1:0]   rr_ptr_i,
    output logic [NUM_REQ-1:0] pick_o,
    output logic [PTR_W-1:0]   pick_idx_o,
    output logic               any_valid_o
);

    logic found;

    // Two passes give the wrapped search order: indices above the pointer
    // first, then from 0 up to and including the pointer itself.
    always_comb begin
        pick_o     = '0;
        pick_idx_o = '0;
        found      = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid_i[i] && (i > int'(rr_ptr_i))) begin
                pick_o[i]  = 1'b1;
                pick_idx_o = PTR_W'(i);
                found      = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid_i[i] && (i <= int'(rr_ptr_i))) begin
                pick_o[i]  = 1'b1;
                pick_idx_o = PTR_W'(i);
                found      = 1'b1;
            end
        end
    end

    assign any_valid_o = found;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX serialiser among NUM_REQ byte streams, round-robin per packet.
// Latency: valid in IDLE -> handshake >=1 cycle later -> txStart the cycle after handshake.
// Backpressure: reqReady only to the grant owner and only while txBusy is low.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   reqValid     NUM_REQ    per-requester byte valid
//   reqData      8*NUM_REQ  byte i at [8*i+7:8*i]
//   reqLast      NUM_REQ    byte ends the packet
//   reqReady     NUM_REQ    per-requester accept (combinational)
//   grant        NUM_REQ    one-hot packet owner, 0 when idle
//   txStart      1          one-cycle start pulse to the serialiser
//   txData       8          byte to serialise, held until the next txStart
//   txBusy       1          serialiser busy
//   timeoutErr   1          one-cycle pulse on forced release
//
// Build option TX_ARB_TIMEOUT_EN: releases a grant whose owner has gone quiet
// for TIMEOUT_CYCLES cycles in ST_LOCKED. Without it the grant is held forever
// and timeoutErr is tied low.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
`ifdef TX_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
`endif
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             reqValid,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] reqData,
    input  logic [NUM_REQ-1:0]             reqLast,
    output logic [NUM_REQ-1:0]             reqReady,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           txStart,
    output logic [UART_BYTE_W-1:0]         txData,
    input  logic                           txBusy,
    output logic                           timeoutErr
);

    localparam int PTR_W = ptr_w(NUM_REQ);

    eArbState                 state_q, state_d;
    logic [NUM_REQ-1:0]       grant_q, grant_d;
    logic [PTR_W-1:0]         gidx_q, gidx_d;
    logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [UART_BYTE_W-1:0]   tx_data_q, tx_data_d;
    logic                     tx_start_q, tx_start_d;
    logic                     last_q, last_d;

    logic [NUM_REQ-1:0]       pick;
    logic [PTR_W-1:0]         pick_idx;
    logic                     any_valid;

    logic                     owner_vld;
    logic                     owner_last;
    logic [UART_BYTE_W-1:0]   owner_dat;
    logic                     handshake;
    logic                     to_fire;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_picker (
        .req_valid_i (reqValid),
        .rr_ptr_i    (rr_ptr_q),
        .pick_o      (pick),
        .pick_idx_o  (pick_idx),
        .any_valid_o (any_valid)
    );

    // Select the owner's lane using the one-hot grant.
    always_comb begin
        owner_vld  = 1'b0;
        owner_last = 1'b0;
        owner_dat  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                owner_vld  = reqValid[i];
                owner_last = reqLast[i];
                owner_dat  = reqData[UART_BYTE_W*i +: UART_BYTE_W];
            end
        end
    end

    // A busy serialiser on entry to LOCKED (foreign traffic) also holds off the owner.
    assign reqReady  = ((state_q == ST_LOCKED) && !txBusy) ? grant_q : '0;
    assign handshake = (state_q == ST_LOCKED) && owner_vld && !txBusy;

`ifdef TX_ARB_TIMEOUT_EN
    logic [31:0] to_cnt_q, to_cnt_d;
    logic        timeout_q;

    // Counts only while the owner is silent in LOCKED; any other cycle clears it.
    always_comb begin
        to_cnt_d = '0;
        to_fire  = 1'b0;
        if ((state_q == ST_LOCKED) && !owner_vld) begin
            if (to_cnt_q == TIMEOUT_CYCLES - 1) begin
                to_fire = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= to_fire;
        end
    end

    assign timeoutErr = timeout_q;
`else
    assign to_fire    = 1'b0;
    assign timeoutErr = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        rr_ptr_d   = rr_ptr_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        last_d     = last_q;
        case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    grant_d = pick;
                    gidx_d  = pick_idx;
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (to_fire) begin
                    rr_ptr_d = gidx_q;
                    grant_d  = '0;
                    state_d  = ST_IDLE;
                end else if (handshake) begin
                    tx_data_d  = owner_dat;
                    last_d     = owner_last;
                    tx_start_d = 1'b1;
                    state_d    = ST_GUARD;
                end
            end
            // txBusy only rises the cycle after txStart, so it is not
            // meaningful here; spend one cycle before watching it.
            ST_GUARD: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!txBusy) begin
                    if (last_q) begin
                        rr_ptr_d = gidx_q;
                        grant_d  = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            rr_ptr_q   <= PTR_W'(NUM_REQ - 1);
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            last_q     <= last_d;
        end
    end

    assign grant   = grant_q;
    assign txStart = tx_start_q;
    assign txData  = tx_data_q;

endmodule
